hazard_unit: RTL and testbench

- Pipeline control stage for the 5-stage ARM pipeline (F/D/E/M/W).
- Sits directly upstream of the pipeline registers and drives their enable and clear inputs: stalls go to active-low enables, flushes go to synchronous clears.
- Detects load-use and PC-write hazards, selects operand forwarding for E, and sequences a multi-cycle multiplier held in E with an internal FSM/counter.

---
 rtl/hazard_unit_pkg.sv | 14 +
 rtl/hazard_unit_if.sv | 20 ++
 rtl/hazard_unit_mul_seq.sv | 42 ++++
 rtl/hazard_unit.sv | 32 +++
 tb/tb_hazard_unit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared types, forward-select codes and multiplier FSM states.
package hazard_unit_pkg;
  localparam int REG_W = 4;
  typedef logic [REG_W-1:0] reg_t;
  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_RF = 2'b00;
  localparam fwd_t FWD_W  = 2'b01;
  localparam fwd_t FWD_M  = 2'b10;
  typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_e;
  function automatic fwd_t fwd_sel(input logic reg_wr_m, input reg_t wa_m,
                                   input logic reg_wr_w, input reg_t wa_w, input reg_t ra);
    return (reg_wr_m && wa_m == ra) ? FWD_M : (reg_wr_w && wa_w == ra) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side view of the hazard unit (hazard inputs, stall/flush/forward outputs).
interface hazard_unit_if #(parameter int CNT_W = 4);
  import hazard_unit_pkg::*;
  reg_t RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  fwd_t ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
  logic [CNT_W-1:0] MulCount;
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulCount
  );
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulCount
  );
endinterface

// File: rtl/hazard_unit_mul_seq.sv
// mul_seq: holds a multi-cycle MUL in E for MUL_CYCLES cycles, stalling for all but the last.
module mul_seq
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_start_i,
  output logic             mul_stall_o,
  output logic             mul_busy_o,
  output logic [CNT_W-1:0] mul_count_o
);
  if (MUL_CYCLES < 2) begin : g_bad_cycles
    $error("mul_seq: MUL_CYCLES must be >= 2");
  end
  if ((2 ** CNT_W) <= MUL_CYCLES) begin : g_bad_width
    $error("mul_seq: CNT_W too narrow for MUL_CYCLES");
  end
  mul_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic idle_start, busy_run;
  always_comb begin
    idle_start  = state_q == MUL_IDLE && mul_start_i;
    busy_run    = state_q == MUL_BUSY && cnt_q != '0;
    mul_stall_o = idle_start || busy_run;
    state_d     = idle_start ? MUL_BUSY : (state_q == MUL_BUSY && !busy_run) ? MUL_IDLE : state_q;
    cnt_d       = idle_start ? CNT_W'(MUL_CYCLES - 2) : busy_run ? cnt_q - CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mul_busy_o  = state_q == MUL_BUSY;
  assign mul_count_o = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use/PC-write hazard detection, E-stage forwarding and multiplier stall control.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input logic         clk,
  input logic         reset,
  hazard_unit_if.slave hz
);
  logic ldr_stall, pc_wr_pending, mul_stall;
  mul_seq #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) u_mul_seq (
    .clk         (clk),
    .reset       (reset),
    .mul_start_i (hz.MulStartE),
    .mul_stall_o (mul_stall),
    .mul_busy_o  (hz.MulBusy),
    .mul_count_o (hz.MulCount)
  );
  assign hz.ForwardAE = fwd_sel(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA1E);
  assign hz.ForwardBE = fwd_sel(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA2E);
  assign ldr_stall     = hz.MemtoRegE && (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
  assign pc_wr_pending = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
  assign hz.StallF = ldr_stall || pc_wr_pending || mul_stall;
  assign hz.StallD = ldr_stall || mul_stall;
  assign hz.StallE = mul_stall;
  // Clears are masked while the multiplier holds E so no stage is both held and cleared.
  assign hz.FlushD = (pc_wr_pending || hz.PCSrcW || hz.BranchTakenE) && !mul_stall;
  assign hz.FlushE = (ldr_stall || hz.BranchTakenE) && !mul_stall;
  assign hz.FlushM = mul_stall;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: vector table, hand MUL/reset sequences and randomized checks against a reference model.
module tb_hazard_unit;
  localparam int MC = 3;
  localparam int CW = 4;
  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwm, rww, m2r, pcd, pce, pcm, pcw, bte, mul;
  } in_t;
  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm, busy;
    logic [CW-1:0] cnt;
  } out_t;
  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;
  logic clk, reset;
  int tests = 0, fails = 0, k = 0;
  vec_t tbl[$];
  hazard_unit_if #(.CNT_W(CW)) hz ();
  hazard_unit #(.MUL_CYCLES(MC), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .hz(hz));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  task automatic drive(input in_t v);
    {hz.RA1D, hz.RA2D, hz.RA1E, hz.RA2E, hz.WA3E, hz.WA3M, hz.WA3W} = {v.ra1d, v.ra2d, v.ra1e, v.ra2e, v.wa3e, v.wa3m, v.wa3w};
    {hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE} = {v.rwm, v.rww, v.m2r};
    {hz.PCSrcD, hz.PCSrcE, hz.PCSrcM, hz.PCSrcW, hz.BranchTakenE, hz.MulStartE} = {v.pcd, v.pce, v.pcm, v.pcw, v.bte, v.mul};
  endtask
  function automatic out_t dut_out();
    return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM, hz.MulBusy, hz.MulCount};
  endfunction
  function automatic logic [1:0] fwd(input in_t v, input logic [3:0] ra);
    if (v.rwm && v.wa3m == ra) return 2'b10;
    if (v.rww && v.wa3w == ra) return 2'b01;
    return 2'b00;
  endfunction
  // pos: 1..MC position of the MUL currently in E, 0 when none.
  function automatic out_t model(input in_t v, input int pos);
    out_t o;
    logic ldr, pcw, ms;
    ldr = v.m2r && (v.wa3e == v.ra1d || v.wa3e == v.ra2d);
    pcw = v.pcd || v.pce || v.pcm;
    ms  = pos >= 1 && pos < MC;
    o.fa = fwd(v, v.ra1e);
    o.fb = fwd(v, v.ra2e);
    o.sf = ldr || pcw || ms;
    o.sd = ldr || ms;
    o.se = ms;
    o.fd = (pcw || v.pcw || v.bte) && !ms;
    o.fe = (ldr || v.bte) && !ms;
    o.fm = ms;
    o.busy = pos >= 2;
    o.cnt = pos >= 2 ? CW'(MC - pos) : '0;
    return o;
  endfunction
  task automatic check(input string name, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got fa=%b fb=%b sFDE=%b%b%b flDEM=%b%b%b busy=%b cnt=%0d, want fa=%b fb=%b sFDE=%b%b%b flDEM=%b%b%b busy=%b cnt=%0d",
               name, act.fa, act.fb, act.sf, act.sd, act.se, act.fd, act.fe, act.fm, act.busy, act.cnt,
               exp.fa, exp.fb, exp.sf, exp.sd, exp.se, exp.fd, exp.fe, exp.fm, exp.busy, exp.cnt);
    end
  endtask
  // One cycle: inputs applied just after posedge, outputs checked at negedge, model advanced.
  task automatic run(input string name, input in_t v, input bit hand, input out_t hexp);
    int pos;
    drive(v);
    @(negedge clk);
    pos = reset ? 0 : k;
    if (pos == 0 && v.mul) pos = 1;
    check(name, dut_out(), hand ? hexp : model(v, pos));
    k = (reset || pos == 0 || pos == MC) ? 0 : pos + 1;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input string n, input in_t i, input out_t o);
    vec_t e;
    e.name = n;
    e.i = i;
    e.o = o;
    tbl.push_back(e);
  endtask
  initial begin
    in_t vi, z;
    out_t vo, zo;
    z = '0;
    zo = '0;
    reset = 1;
    drive(z);
    @(posedge clk);
    #1;
    run("reset_quiet", z, 1, zo);
    reset = 0;
    vi = '{ra1e: 4'd3, wa3m: 4'd3, rwm: 1'b1, wa3w: 4'd3, rww: 1'b1, default: '0};
    vo = '{fa: 2'b10, default: '0};
    add("fwdA_M_priority", vi, vo);
    vi.rwm = 1'b0;
    vo = '{fa: 2'b01, default: '0};
    add("fwdA_W", vi, vo);
    vi = '{ra2e: 4'd5, wa3m: 4'd6, rwm: 1'b1, wa3w: 4'd7, rww: 1'b1, ra1e: 4'd1, default: '0};
    add("fwdB_none", vi, zo);
    vi = '{ra2e: 4'd9, wa3m: 4'd9, rwm: 1'b1, wa3w: 4'd9, ra1e: 4'd1, default: '0};
    vo = '{fb: 2'b10, default: '0};
    add("fwdB_M_needs_rw", vi, vo);
    vi = '{m2r: 1'b1, wa3e: 4'd4, ra2d: 4'd4, ra1d: 4'd1, default: '0};
    vo = '{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: '0};
    add("ldr_use_ra2", vi, vo);
    vi = '{m2r: 1'b1, wa3e: 4'd7, ra1d: 4'd7, ra2d: 4'd2, default: '0};
    add("ldr_use_ra1", vi, vo);
    vi = '{m2r: 1'b1, wa3e: 4'd4, ra1d: 4'd5, ra2d: 4'd5, default: '0};
    add("ldr_no_match", vi, zo);
    vi = '{bte: 1'b1, default: '0};
    vo = '{fd: 1'b1, fe: 1'b1, default: '0};
    add("branch_taken", vi, vo);
    vi = '{pcd: 1'b1, default: '0};
    vo = '{sf: 1'b1, fd: 1'b1, default: '0};
    add("pcsrc_d", vi, vo);
    vi = '{pcm: 1'b1, default: '0};
    add("pcsrc_m", vi, vo);
    vi = '{pcw: 1'b1, default: '0};
    vo = '{fd: 1'b1, default: '0};
    add("pcsrc_w", vi, vo);
    add("quiet", z, zo);
    foreach (tbl[i]) run(tbl[i].name, tbl[i].i, 1, tbl[i].o);
    vi = '{mul: 1'b1, default: '0};
    run("mul_c1", vi, 1, '{sf: 1'b1, sd: 1'b1, se: 1'b1, fm: 1'b1, default: '0});
    run("mul_c2", vi, 1, '{sf: 1'b1, sd: 1'b1, se: 1'b1, fm: 1'b1, busy: 1'b1, cnt: CW'(1), default: '0});
    run("mul_c3", vi, 1, '{busy: 1'b1, default: '0});
    run("mul_b2b_c1", vi, 1, '{sf: 1'b1, sd: 1'b1, se: 1'b1, fm: 1'b1, default: '0});
    vi = '{mul: 1'b1, m2r: 1'b1, wa3e: 4'd4, ra2d: 4'd4, ra1d: 4'd1, bte: 1'b1, default: '0};
    run("mul_plus_ldr", vi, 1, '{sf: 1'b1, sd: 1'b1, se: 1'b1, fm: 1'b1, busy: 1'b1, cnt: CW'(1), default: '0});
    run("mul_b2b_c3", z, 1, '{busy: 1'b1, default: '0});
    vi = '{mul: 1'b1, default: '0};
    run("mul_restart", vi, 1, '{sf: 1'b1, sd: 1'b1, se: 1'b1, fm: 1'b1, default: '0});
    reset = 1;
    run("reset_in_busy", z, 1, zo);
    reset = 0;
    run("after_reset", z, 1, zo);
    repeat (400) begin
      vi = '0;
      vi.ra1d = 4'($urandom_range(0, 3));
      vi.ra2d = 4'($urandom_range(0, 3));
      vi.ra1e = 4'($urandom_range(0, 3));
      vi.ra2e = 4'($urandom_range(0, 3));
      vi.wa3e = 4'($urandom_range(0, 3));
      vi.wa3m = 4'($urandom_range(0, 3));
      vi.wa3w = 4'($urandom_range(0, 3));
      {vi.rwm, vi.rww, vi.m2r} = 3'($urandom);
      vi.pcd = $urandom_range(0, 5) == 0;
      vi.pce = $urandom_range(0, 5) == 0;
      vi.pcm = $urandom_range(0, 5) == 0;
      vi.pcw = $urandom_range(0, 5) == 0;
      vi.bte = $urandom_range(0, 4) == 0;
      vi.mul = $urandom_range(0, 2) == 0;
      reset = $urandom_range(0, 40) == 0;
      run("random", vi, 0, zo);
    end
    reset = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
